// File: rtl/servo_pulse_capture.sv
// Servo PWM pulse-width capture: measures high time in whole microseconds.
// Optional glitch filter enabled by defining SERVO_CAPTURE_FILTER_EN.
module servo_pulse_capture #(
  parameter int TICKS_PER_US  = 25,
  parameter int MIN_US        = 500,
  parameter int MAX_US        = 2500,
  parameter int TIMEOUT_TICKS = 1000000,
  parameter int FILTER_LEN    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PMOD,
  output logic [31:0] width_us,
  output logic        valid,
  output logic        range_err,
  output logic        signal_lost
);

  localparam int PW =
    (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  if (FILTER_LEN < 2 || MIN_US > MAX_US) begin : g_bad_cfg
    $error("servo_pulse_capture: bad parameters");
  end

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH,
    OVERRUN
  } state_t;

  state_t         state;
  logic           s1;
  logic           s2;
  logic           lvl;
  logic           lvl_d;
  logic           rise;
  logic           fall;
  logic [PW-1:0]  presc;
  logic [31:0]    us_cnt;
  logic [31:0]    us_nxt;
  logic           wrap;
  logic [31:0]    loss_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= PMOD;
      s2 <= s1;
    end
  end

`ifdef SERVO_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);
  // ARM must not trust lvl until the filter has had time to settle
  localparam int PRIME = FILTER_LEN + 1;

  logic [FW-1:0] fcnt;
  logic          flt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fcnt <= '0;
      flt  <= 1'b0;
    end else if (s2 == flt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 2)) begin
      fcnt <= '0;
      flt  <= s2;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = flt;
`else
  localparam int PRIME = 2;

  assign lvl = s2;
`endif

  localparam int PCW = $clog2(PRIME + 1);

  logic [PCW-1:0] prime_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // us_nxt includes the current cycle, so the fall cycle is counted
  assign wrap   = (presc == PW'(TICKS_PER_US - 1));
  assign us_nxt = us_cnt + {31'd0, wrap};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ARM;
      prime_cnt <= '0;
      presc     <= '0;
      us_cnt    <= '0;
      width_us  <= '0;
      valid     <= 1'b0;
      range_err <= 1'b0;
      loss_cnt  <= 32'(TIMEOUT_TICKS);
    end else begin
      valid     <= 1'b0;
      range_err <= 1'b0;
      if (loss_cnt != 32'(TIMEOUT_TICKS)) begin
        loss_cnt <= loss_cnt + 32'd1;
      end
      unique case (state)
        ARM: begin
          if (prime_cnt != PCW'(PRIME)) begin
            prime_cnt <= prime_cnt + 1'b1;
          end else if (!lvl) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (rise) begin
            state  <= HIGH;
            presc  <= '0;
            us_cnt <= '0;
          end
        end
        HIGH: begin
          presc  <= wrap ? '0 : presc + 1'b1;
          us_cnt <= us_nxt;
          if (fall) begin
            state <= IDLE;
            if (us_nxt >= 32'(MIN_US) &&
                us_nxt <= 32'(MAX_US)) begin
              width_us <= us_nxt;
              valid    <= 1'b1;
              loss_cnt <= '0;
            end else begin
              range_err <= 1'b1;
            end
          end else if (us_nxt == 32'(MAX_US + 1)) begin
            range_err <= 1'b1;
            state     <= OVERRUN;
          end
        end
        OVERRUN: begin
          if (fall) begin
            state <= IDLE;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

  assign signal_lost = (loss_cnt == 32'(TIMEOUT_TICKS));

endmodule

// File: tb/tb_servo_pulse_capture.sv
// Bench for servo_pulse_capture: random pulses vs. an arithmetic model.
// Scaled parameters keep each pulse to a few hundred cycles.
module tb_servo_pulse_capture;

  localparam int T    = 3;
  localparam int MINU = 10;
  localparam int MAXU = 40;
  localparam int TO   = 3000;
  localparam int FL   = 4;
`ifdef SERVO_CAPTURE_FILTER_EN
  localparam int LAT = 1 + FL;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmod = 1'b0;
  logic [31:0] width_us;
  logic        valid;
  logic        range_err;
  logic        signal_lost;

  always #5 clk = ~clk;

  servo_pulse_capture #(
    .TICKS_PER_US (T),
    .MIN_US       (MINU),
    .MAX_US       (MAXU),
    .TIMEOUT_TICKS(TO),
    .FILTER_LEN   (FL)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .PMOD       (pmod),
    .width_us   (width_us),
    .valid      (valid),
    .range_err  (range_err),
    .signal_lost(signal_lost)
  );

  typedef struct {
    int c;
    bit ok;
    int w;
    bit lost;
  } ev_t;

  int  cyc = 0;
  int  lastv = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  model_w = 0;
  ev_t evq[$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: one entry per strobe cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid || range_err) begin
        evq.push_back('{cyc, valid, int'(width_us),
                        signal_lost});
      end
      if (valid) lastv = cyc;
      if (valid && range_err) check("exclusive", 1, 0);
    end
  end

  // Drive h high cycles then gap low cycles, then judge the pulse
  task automatic pulse(int h, int gap, string tag);
    int  r;
    int  f;
    int  n;
    int  ec;
    int  ne;
    bit  eok;
    ev_t ev;
    @(negedge clk);
    pmod = 1'b1;
    r = cyc + 1;
    repeat (h) @(negedge clk);
    pmod = 1'b0;
    f  = r + h;
    n  = h / T;
    ne = 1;
    if (h >= (MAXU + 1) * T) begin
      ec  = r + LAT + (MAXU + 1) * T;
      eok = 1'b0;
    end else begin
      ec  = f + LAT;
      eok = (n >= MINU && n <= MAXU);
    end
`ifdef SERVO_CAPTURE_FILTER_EN
    if (h < FL) ne = 0;
`endif
    repeat (gap) @(negedge clk);
    check({tag, " count"}, evq.size(), ne);
    if (evq.size() > 0 && ne == 1) begin
      ev = evq.pop_front();
      check({tag, " when"}, ev.c, ec);
      check({tag, " kind"}, {31'd0, ev.ok}, {31'd0, eok});
      if (eok) begin
        check({tag, " w"}, ev.w, n);
        check({tag, " lost"}, {31'd0, ev.lost}, 0);
        model_w = n;
      end
    end
    check({tag, " width"}, width_us, model_w);
    evq.delete();
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, " width"}, width_us, 0);
    check({tag, " valid"}, {31'd0, valid}, 0);
    check({tag, " rerr"}, {31'd0, range_err}, 0);
    check({tag, " lost"}, {31'd0, signal_lost}, 1);
  endtask

  initial begin
    pmod  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    repeat (20 * T) @(negedge clk);
    pmod = 1'b0;
    repeat (20) @(negedge clk);
    check("arm count", evq.size(), 0);
    evq.delete();

    pulse(15 * T, 40, "first");
    pulse(25 * T, 40, "mid");
    pulse(15 * T + 1, 40, "frac");
    pulse(MINU * T, 40, "min");
    pulse(MINU * T - 1, 40, "below");
    pulse(MAXU * T, 40, "max");
    pulse((MAXU + 1) * T - 1, 40, "maxhi");
    pulse(60 * T, 40, "over");
    pulse(20 * T, 40, "post_over");
    pulse(2, 40, "glitch");
    for (int i = 0; i < 16; i++) begin
      pulse($urandom_range(FL, (MAXU + 6) * T),
            $urandom_range(20, 80), "rand");
    end

    pulse(30 * T, 20, "last");
    while (cyc < lastv + TO - 1) @(negedge clk);
    check("lost before", {31'd0, signal_lost}, 0);
    @(negedge clk);
    check("lost at", {31'd0, signal_lost}, 1);
    pulse(5 * T, 30, "rej_lost");
    check("lost held", {31'd0, signal_lost}, 1);
    pulse(22 * T, 30, "recover");
    check("lost clr", {31'd0, signal_lost}, 0);

    @(negedge clk);
    pmod = 1'b1;
    repeat (20 * T) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    model_w = 0;
    @(negedge clk);
    rst_n = 1'b1;
    evq.delete();
    repeat (10 * T) @(negedge clk);
    pmod = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst count", evq.size(), 0);
    evq.delete();
    pulse(18 * T, 30, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
